// File: rtl/uart_tx_arbiter_if.sv
// Bundle of the producer-side handshake and the uart_tx-side control signals
// shared by the round-robin transmit arbiter and its environment.
interface uart_tx_arbiter_if #(
    parameter int N = 8,
    parameter int R = 4
);
    localparam int ID_W = (R > 1) ? $clog2(R) : 1;

    logic [R-1:0]    req_valid;
    logic [R*N-1:0]  req_data;
    logic [R-1:0]    req_ready;
    logic            tx_start;
    logic [N-1:0]    tx_data;
    logic            tx_busy;
    logic [ID_W-1:0] grant_id;
    logic            active;
    logic            timeout_err;

    modport slave (
        input  req_valid, req_data, tx_busy,
        output req_ready, tx_start, tx_data, grant_id, active, timeout_err
    );

    modport master (
        output req_valid, req_data, tx_busy,
        input  req_ready, tx_start, tx_data, grant_id, active, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between R byte producers, with a
// watchdog on the transmitter acknowledging each start pulse via busy.
module uart_tx_arbiter #(
    parameter int N       = 8,
    parameter int R       = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int ID_W  = (R > 1) ? $clog2(R) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t          state;
    logic [ID_W-1:0] last;
    logic [ID_W-1:0] grant_q;
    logic [N-1:0]    tx_data_q;
    logic            tx_start_q;
    logic            timeout_q;
    logic [CNT_W-1:0] cnt;

    logic [ID_W-1:0] sel_idx;
    logic            sel_found;
    logic            grant;
    int              idx;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        sel_idx   = '0;
        sel_found = 1'b0;
        idx       = 0;
        for (int k = 1; k <= R; k++) begin
            idx = (int'(last) + k) % R;
            if (!sel_found && bus.req_valid[idx]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'(idx);
            end
        end
    end

    assign grant = (state == IDLE) && !bus.tx_busy && sel_found;

    assign bus.req_ready   = (grant && !reset) ? ({{(R-1){1'b0}}, 1'b1} << sel_idx) : '0;
    assign bus.tx_start    = tx_start_q;
    assign bus.tx_data     = tx_data_q;
    assign bus.grant_id    = grant_q;
    assign bus.active      = (state != IDLE);
    assign bus.timeout_err = timeout_q;

    // The error pulse is raised on the cycle the counter hits TIMEOUT; the
    // return to IDLE happens one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last       <= ID_W'(R - 1);
            grant_q    <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            cnt        <= '0;
        end else begin
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        tx_data_q  <= bus.req_data[sel_idx*N +: N];
                        grant_q    <= sel_idx;
                        last       <= sel_idx;
                        tx_start_q <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    cnt   <= '0;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (cnt == CNT_W'(TIMEOUT)) begin
                        state <= IDLE;
                    end else if (bus.tx_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        cnt       <= cnt + CNT_W'(1);
                        timeout_q <= (cnt == CNT_W'(TIMEOUT - 1));
                    end
                end
                WAIT_DONE: begin
                    if (!bus.tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: grants, round-robin order, pointer wrap,
// timeout, busy blocking and mid-frame reset, with hand-computed expectations.
module tb_uart_tx_arbiter;
    localparam int N       = 8;
    localparam int R       = 4;
    localparam int TIMEOUT = 16;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   onehot_violations;

    uart_tx_arbiter_if #(.N(N), .R(R)) bus ();

    uart_tx_arbiter #(.N(N), .R(R), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(bus.req_ready) > 1) onehot_violations++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [R-1:0] valid, input logic [R*N-1:0] data, input logic busy);
        bus.req_valid = valid;
        bus.req_data  = data;
        bus.tx_busy   = busy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered in IDLE just after an edge with the request already driven.
    task automatic runFrame(input int exp_id, input logic [N-1:0] exp_data, input int busy_cycles);
        #1;
        checkOutput("grant_ready", 32'(bus.req_ready), 32'(1) << exp_id);
        step();
        checkOutput("start_pulse", 32'(bus.tx_start), 32'd1);
        checkOutput("start_data", 32'(bus.tx_data), 32'(exp_data));
        checkOutput("start_grant_id", 32'(bus.grant_id), 32'(exp_id));
        checkOutput("start_ready_low", 32'(bus.req_ready), 32'd0);
        step();
        checkOutput("start_cleared", 32'(bus.tx_start), 32'd0);
        bus.tx_busy = 1'b1;
        repeat (busy_cycles) step();
        checkOutput("busy_active", 32'(bus.active), 32'd1);
        bus.tx_busy = 1'b0;
        step();
        checkOutput("done_idle", 32'(bus.active), 32'd0);
    endtask

    initial begin
        vectors           = 0;
        miscompares       = 0;
        onehot_violations = 0;
        reset = 1'b1;
        applyStimulus(4'b0001, 32'h0000_00AA, 1'b0);
        #2;
        checkOutput("reset_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("reset_start", 32'(bus.tx_start), 32'd0);
        checkOutput("reset_data", 32'(bus.tx_data), 32'd0);
        checkOutput("reset_grant_id", 32'(bus.grant_id), 32'd0);
        checkOutput("reset_active", 32'(bus.active), 32'd0);
        checkOutput("reset_timeout", 32'(bus.timeout_err), 32'd0);
        step();
        reset = 1'b0;

        // Single request from requester 0.
        runFrame(0, 8'hAA, 4);
        applyStimulus(4'b0000, 32'h0000_00AA, 1'b0);
        step();
        checkOutput("single_no_regrant", 32'(bus.req_ready), 32'd0);

        // All requesters held; fresh reset so requester 0 wins first.
        reset = 1'b1;
        step();
        reset = 1'b0;
        applyStimulus(4'b1111, 32'h1312_1110, 1'b0);
        runFrame(0, 8'h10, 20);
        runFrame(1, 8'h11, 20);
        runFrame(2, 8'h12, 20);
        runFrame(3, 8'h13, 20);
        runFrame(0, 8'h10, 20);
        checkOutput("onehot_ready", 32'(onehot_violations), 32'd0);

        // Pointer wrap: winner 2, then 0 and 2 pending.
        applyStimulus(4'b0100, 32'h2C2B_2A29, 1'b0);
        runFrame(2, 8'h2B, 3);
        applyStimulus(4'b0101, 32'h2C2B_2A29, 1'b0);
        runFrame(0, 8'h29, 3);
        runFrame(2, 8'h2B, 3);

        // Timeout with busy stuck low; requester 1 waits behind it.
        applyStimulus(4'b0001, 32'h4443_4241, 1'b0);
        #1;
        checkOutput("to_grant_ready", 32'(bus.req_ready), 32'd1);
        step();
        checkOutput("to_start", 32'(bus.tx_start), 32'd1);
        bus.req_valid = 4'b0010;
        for (int c = 0; c < TIMEOUT; c++) begin
            step();
            checkOutput("to_no_early_err", 32'(bus.timeout_err), 32'd0);
        end
        step();
        checkOutput("to_err_pulse", 32'(bus.timeout_err), 32'd1);
        checkOutput("to_err_active", 32'(bus.active), 32'd1);
        step();
        checkOutput("to_err_cleared", 32'(bus.timeout_err), 32'd0);
        checkOutput("to_back_idle", 32'(bus.active), 32'd0);
        runFrame(1, 8'h42, 3);

        // Busy held high in IDLE blocks the grant.
        applyStimulus(4'b0010, 32'h5453_5251, 1'b1);
        for (int c = 0; c < 3; c++) begin
            #1;
            checkOutput("busy_block_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        checkOutput("busy_block_idle", 32'(bus.active), 32'd0);
        bus.tx_busy = 1'b0;
        runFrame(1, 8'h52, 3);

        // Reset during WAIT_DONE; requester 3 pending afterwards.
        applyStimulus(4'b0100, 32'h6C6B_6A69, 1'b0);
        #1;
        checkOutput("mid_grant_ready", 32'(bus.req_ready), 32'd4);
        step();
        bus.req_valid = 4'b1000;
        step();
        bus.tx_busy = 1'b1;
        step();
        step();
        checkOutput("mid_in_frame", 32'(bus.active), 32'd1);
        checkOutput("mid_data_before", 32'(bus.tx_data), 32'h6B);
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_active", 32'(bus.active), 32'd0);
        checkOutput("mid_rst_start", 32'(bus.tx_start), 32'd0);
        checkOutput("mid_rst_data", 32'(bus.tx_data), 32'd0);
        checkOutput("mid_rst_grant_id", 32'(bus.grant_id), 32'd0);
        checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        step();
        reset = 1'b0;
        #1;
        checkOutput("mid_post_busy_ready", 32'(bus.req_ready), 32'd0);
        step();
        checkOutput("mid_post_busy_idle", 32'(bus.active), 32'd0);
        bus.tx_busy = 1'b0;
        runFrame(3, 8'h6C, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between R byte producers. It accepts a byte from one requester at a time over a valid/ready handshake and pulses `start_tx` into `uart_tx`. It then tracks `busy` until the frame is complete. It also detects a transmitter that never acknowledges a start. It sits between the producer blocks and the `uart_tx` instance.

## Interface
- `N`, 8, data width per byte; must match `uart_tx` `N`.
- `R`, 4, number of requesters, 2..8.
- `TIMEOUT`, 16, max cycles to wait for `tx_busy` to rise after `tx_start`, ≥2.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  R  bit i: requester i holds a byte.
- `req_data`  in  R*N  requester i byte at bits [i*N +: N].
- `req_ready`  out  R  one-hot accept strobe, combinational; byte i taken on the edge where `req_valid[i] & req_ready[i]`.
- `tx_start`  out  1  to `uart_tx.start_tx`; registered one-cycle pulse.
- `tx_data`  out  N  to `uart_tx.data_in`; registered, stable from grant until the next grant.
- `tx_busy`  in  1  from `uart_tx.busy`.
- `grant_id`  out  clog2(R)  index of last granted requester; registered.
- `active`  out  1  high in any state other than IDLE.
- `timeout_err`  out  1  one-cycle pulse when `tx_busy` is not seen within `TIMEOUT` cycles.

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE, grant condition: grant occurs when any `req_valid` is high and `tx_busy` == 0.
  - Select the first set bit searching from `last+1` upward, wrapping modulo R.
  - Drive the selected `req_ready` bit high that cycle.
  - On the edge: latch `tx_data`, set `grant_id` and `last` to the winner, go to START.
  - If `tx_busy` == 1 in IDLE, there is no grant and `req_ready` stays all zero.
- START: `tx_start` = 1 for exactly this cycle. Clear the timeout counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - If `tx_busy` == 1, go to WAIT_DONE.
  - Else increment the counter.
  - When the counter reaches `TIMEOUT`, pulse `timeout_err` for one cycle and return to IDLE. The byte is dropped and is not re-requested.
- WAIT_DONE: stay while `tx_busy` == 1. On `tx_busy` == 0, go to IDLE. There is no timeout in this state.
- `req_ready` is zero in every non-IDLE state. Requesters must keep `req_valid` and `req_data` stable until accepted. Dropping `req_valid` before acceptance is allowed and withdraws the request.
- Fairness: a requester with continuously asserted valid waits at most R-1 other frames.

## Timing
- Reset values (async, immediate): state IDLE, `tx_start` 0, `tx_data` 0, `grant_id` 0, `last` R-1 (requester 0 wins first), `active` 0, `timeout_err` 0, `req_ready` all 0 while `reset` is high.
- Grant in cycle t gives:
  - `tx_data` valid at t+1;
  - `tx_start` high during t+1;
  - WAIT_BUSY from t+2.
- With `uart_tx` raising busy one cycle after start, WAIT_DONE is entered at t+3.
- Back-to-back: after `tx_busy` falls at cycle d, state is IDLE at d+1, and the next grant can occur in cycle d+1.
- Timeout: with `tx_busy` stuck low, `timeout_err` pulses in cycle t+2+`TIMEOUT`, and the state is IDLE the following cycle.
- Simultaneous requests in the same cycle: exactly one `req_ready` bit may be set.
- Reset mid-frame: returns to IDLE at once and the in-flight byte is abandoned. After release, the first grant waits for `tx_busy` == 0.

## Test plan
- Single request: after reset, `req_valid`=4'b0001 with byte 8'hAA.
  - `req_ready[0]` pulses once, then `tx_start` pulses one cycle later with `tx_data`=8'hAA.
  - `grant_id`=0 and `active` stays high until the busy model drops.
- All requesters: `req_valid`=4'b1111 held, bytes 8'h10, 8'h11, 8'h12, 8'h13, busy model 20 cycles per frame.
  - Grant order is 0,1,2,3,0.
  - No two `req_ready` bits are ever high together.
- Pointer wrap: grant requester 2 first, then assert `req_valid`=4'b0101. The next grant is 0, then 2.
- Timeout: hold `tx_busy`=0 after start with `TIMEOUT`=16.
  - `timeout_err` pulses exactly once, 18 cycles after the grant.
  - State returns to IDLE and the next pending request is granted.
- Busy blocking: hold `tx_busy`=1 in IDLE with `req_valid`=4'b0010. There is no `req_ready` until busy falls, and the grant follows the next cycle.
- Reset mid-frame: assert `reset` during WAIT_DONE.
  - Outputs return to reset values immediately.
  - After release, the pending `req_valid`=4'b1000 is granted to 3 (first in order 0..3 among set bits).
